button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_pkg.sv | 21 ++
 rtl/button_debouncer_key_sync.sv | 24 ++
 rtl/button_debouncer.sv | 142 ++++++++++++++
 tb/tb_button_debouncer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button debouncer.
// Imported by the debouncer top; the synchronizer needs nothing from it.
package button_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_SYNC_STAGES     = 32'd2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd500000;
    localparam int unsigned DEF_HOLD_CYCLES     = 32'd50000000;

    // The debounced level counts as "down" in both states that follow an accepted press.
    function automatic logic is_down(input btn_state_e st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/button_debouncer_key_sync.sv
// Multi-flop synchronizer for the raw key input; resets to 1 (key released).
module key_sync #(
    parameter int unsigned STAGES = 32'd2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // Shift chain; bit 0 is the metastability-exposed first stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes key_n, qualifies press/release with a stability
// counter, and reports the debounced level, edge strobes and a long-hold indication.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pio_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic held_long
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(32'd1);

    logic              key_synced_s;
    logic              pressed_s;
    btn_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_inc_s;
    logic              pio_level_q, pio_level_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              held_long_q, held_long_d;

    key_sync #(
        .STAGES (SYNC_STAGES)
    ) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_n),
        .q     (key_synced_s)
    );

    assign pressed_s  = ~key_synced_s;
    assign hold_inc_s = (hold_q == HOLD_MAX) ? hold_q : (hold_q + HOLD_ONE);

    // Debounce FSM next-state, stability counter and saturating hold counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            ST_RELEASED: begin
                cnt_d  = '0;
                hold_d = '0;
                if (pressed_s) begin
                    state_d = ST_PRESS_WAIT;
                end else begin
                    state_d = ST_RELEASED;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                cnt_d  = '0;
                hold_d = hold_inc_s;
                if (!pressed_s) begin
                    state_d = ST_RELEASE_WAIT;
                end else begin
                    state_d = ST_PRESSED;
                end
            end
            ST_RELEASE_WAIT: begin
                // A rejected release bounce keeps the hold time already accumulated.
                if (pressed_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    hold_d  = hold_inc_s;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                    hold_d  = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    hold_d = hold_inc_s;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Output registers follow the current state one cycle later; pulses are level edges.
    always_comb begin
        pio_level_d     = is_down(state_q);
        press_pulse_d   = pio_level_d & ~pio_level_q;
        release_pulse_d = ~pio_level_d & pio_level_q;
        held_long_d     = pio_level_d & (hold_q == HOLD_MAX);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RELEASED;
            cnt_q           <= '0;
            hold_q          <= '0;
            pio_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            held_long_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hold_q          <= hold_d;
            pio_level_q     <= pio_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            held_long_q     <= held_long_d;
        end
    end

    assign pio_level     = pio_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign held_long     = held_long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus random key traffic,
// every cycle compared against a run-length reference model of the debouncer.
module tb_button_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 20;

    logic clk = 1'b0;
    logic reset;
    logic key_n;
    logic pio_level, press_pulse, release_pulse, held_long;

    button_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .pio_level     (pio_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .held_long     (held_long)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;
    int edge_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: the accepted level flips once the synchronized key has disagreed
    // with it for DEB+1 consecutive samples; outputs appear one edge after that.
    logic [SYNC-1:0] m_pipe = '1;
    logic m_lvl = 1'b0;
    int   m_run = 0;
    int   m_hold = 0;
    logic exp_pio = 1'b0, exp_press = 1'b0, exp_rel = 1'b0, exp_held = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pipe <= '1; m_lvl <= 1'b0; m_run <= 0; m_hold <= 0;
            exp_pio <= 1'b0; exp_press <= 1'b0; exp_rel <= 1'b0; exp_held <= 1'b0;
        end else begin
            exp_pio   <= m_lvl;
            exp_press <= m_lvl && !exp_pio;
            exp_rel   <= !m_lvl && exp_pio;
            exp_held  <= m_lvl && (m_hold >= HOLD);
            m_pipe    <= {m_pipe[SYNC-2:0], key_n};
            if ((!m_pipe[SYNC-1]) != m_lvl && m_run == DEB) begin
                m_lvl  <= !m_pipe[SYNC-1];
                m_run  <= 0;
                m_hold <= 0;
            end else begin
                m_run <= ((!m_pipe[SYNC-1]) != m_lvl) ? m_run + 1 : 0;
                if (m_lvl && m_hold < HOLD) m_hold <= m_hold + 1;
            end
        end
    end

    // Per-cycle comparison plus event bookkeeping for the directed scenarios.
    int rise_cnt = 0, fall_cnt = 0, held_rise_cnt = 0, press_cnt = 0, rel_cnt = 0;
    int last_rise = 0, last_fall = 0, last_held_rise = 0, last_held_fall = 0;
    logic pio_prev = 1'b0, held_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        check_value("pio_level", pio_level, exp_pio);
        check_value("press_pulse", press_pulse, exp_press);
        check_value("release_pulse", release_pulse, exp_rel);
        check_value("held_long", held_long, exp_held);
        check_value("pulse_excl", press_pulse & release_pulse, 0);
        if (pio_level && !pio_prev) begin rise_cnt++; last_rise = edge_cnt; end
        if (!pio_level && pio_prev) begin fall_cnt++; last_fall = edge_cnt; end
        if (held_long && !held_prev) begin held_rise_cnt++; last_held_rise = edge_cnt; end
        if (!held_long && held_prev) last_held_fall = edge_cnt;
        if (press_pulse) press_cnt++;
        if (release_pulse) rel_cnt++;
        pio_prev  = pio_level;
        held_prev = held_long;
    end

    function automatic int event_count(input int which);
        case (which)
            0: return rise_cnt;
            1: return fall_cnt;
            2: return held_rise_cnt;
            default: return 0;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input string tag, input int which, input int target, input int budget);
        int n = 0;
        while (event_count(which) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_seen"}, (event_count(which) >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    int rel_start, snap_press, snap_rise, rst_edge, len;

    initial begin
        reset = 1'b1;
        key_n = 1'b1;
        while (edge_cnt < 3) @(negedge clk);
        check_value("rst_pio", pio_level, 0);
        check_value("rst_press", press_pulse, 0);
        check_value("rst_held", held_long, 0);
        reset = 1'b0;

        // Clean press sampled first at edge 10; level must rise at edge 21.
        while (edge_cnt < 9) @(negedge clk);
        key_n = 1'b0;
        wait_until("press_rise", 0, 1, 40);
        check_value("press_edge", last_rise, 21);
        check_value("press_pulses", press_cnt, 1);
        check_value("press_no_rel", rel_cnt, 0);

        // Long hold: key low for 40 samples in total, then released.
        wait_until("held_rise", 2, 1, 40);
        check_value("held_delay", last_held_rise - last_rise, 20);
        while (edge_cnt < 49) @(negedge clk);
        key_n = 1'b1;
        rel_start = edge_cnt + 1;
        wait_until("long_fall", 1, 1, 40);
        check_value("long_rel_lat", last_fall - rel_start, 11);
        check_value("long_held_off", held_long, 0);
        check_value("long_held_fall", last_held_fall, last_fall);
        check_value("long_rel_pulses", rel_cnt, 1);

        // Short press: held_long must never assert.
        step(5);
        key_n = 1'b0;
        wait_until("short_rise", 0, 2, 40);
        step(5);
        key_n = 1'b1;
        rel_start = edge_cnt + 1;
        wait_until("short_fall", 1, 2, 40);
        check_value("short_rel_lat", last_fall - rel_start, 11);
        check_value("short_no_held", held_rise_cnt, 1);
        check_value("short_rel_pulses", rel_cnt, 2);

        // Press bounce: 5 low, 1 high, 3 low, then high -- nothing accepted.
        step(5);
        snap_press = press_cnt;
        snap_rise  = rise_cnt;
        key_n = 1'b0; step(5);
        key_n = 1'b1; step(1);
        key_n = 1'b0; step(3);
        key_n = 1'b1; step(30);
        check_value("bounce_no_rise", rise_cnt, snap_rise);
        check_value("bounce_no_press", press_cnt, snap_press);
        check_value("bounce_no_rel", rel_cnt, 2);

        // Release glitch while pressed: level holds, hold timing unaffected.
        key_n = 1'b0;
        wait_until("glitch_rise", 0, 3, 40);
        step(3);
        key_n = 1'b1; step(4);
        key_n = 1'b0; step(25);
        check_value("glitch_level", pio_level, 1);
        check_value("glitch_no_fall", fall_cnt, 2);
        check_value("glitch_no_rel", rel_cnt, 2);
        wait_until("glitch_held", 2, 2, 20);
        check_value("glitch_held_delay", last_held_rise - last_rise, 20);
        key_n = 1'b1;
        wait_until("glitch_fall", 1, 3, 40);

        // Reset pulse during press qualification, key stays low.
        step(5);
        snap_press = press_cnt;
        key_n = 1'b0; step(5);
        reset = 1'b1; step(1);
        reset = 1'b0;
        rst_edge = edge_cnt;
        check_value("midrst_pio", pio_level, 0);
        check_value("midrst_no_press", press_cnt, snap_press);
        wait_until("midrst_rise", 0, 4, 40);
        check_value("midrst_lat", last_rise - (rst_edge + 1), 11);
        key_n = 1'b1;
        wait_until("midrst_fall", 1, 4, 40);

        // Random key traffic with occasional short resets, checked by the model.
        for (int i = 0; i < 400; i++) begin
            key_n = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 40)) : int'($urandom_range(1, 12));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                step(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end
            step(len);
        end
        key_n = 1'b1;
        step(40);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
